// File: rtl/pipe_ctrl_pkg.sv
// Shared types for pipeline hazard control and trace monitors.
// Action encoding maps one-to-one onto the freeze/flush bundle.
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_BUBBLE,
        ACT_FLUSH,
        ACT_STALL
    } act_t;

    typedef struct packed {
        logic freeze_front;
        logic freeze_back;
        logic flush_IF;
        logic flush_ID;
    } ctrl_t;

    function automatic ctrl_t act_ctrl(input act_t a);
        ctrl_t c;
        c = '0;
        unique case (a)
            ACT_STALL: begin
                c.freeze_front = 1'b1;
                c.freeze_back  = 1'b1;
            end
            ACT_FLUSH: begin
                c.flush_IF = 1'b1;
                c.flush_ID = 1'b1;
            end
            ACT_BUBBLE: begin
                c.freeze_front = 1'b1;
                c.flush_ID     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Source/destination compare between ID and the EXE/MEM producers.
// Combinational; the priority against stalls and branches lives upstream.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic             fwd_en,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic             src1_vld_ID,
    input  logic             src2_vld_ID,
    input  logic [REG_W-1:0] dest_EXE,
    input  logic             WB_EN_EXE,
    input  logic             MEM_R_EN_EXE,
    input  logic [REG_W-1:0] dest_MEM,
    input  logic             WB_EN_MEM,
    output logic             hazard
);

    logic exe_prod;
    logic mem_prod;
    logic hz1;
    logic hz2;

    // With forwarding, only a load in EXE cannot be bypassed in time.
    assign exe_prod = fwd_en ? MEM_R_EN_EXE : WB_EN_EXE;
    assign mem_prod = ~fwd_en & WB_EN_MEM;

    assign hz1 = src1_vld_ID &
                 ((exe_prod & (src1_ID == dest_EXE)) |
                  (mem_prod & (src1_ID == dest_MEM)));

    assign hz2 = src2_vld_ID &
                 ((exe_prod & (src2_ID == dest_EXE)) |
                  (mem_prod & (src2_ID == dest_MEM)));

    assign hazard = hz1 | hz2;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush control for the stage registers, memory-wait watchdog
// and saturating stall/bubble/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic             src1_vld_ID,
    input  logic             src2_vld_ID,
    input  logic [REG_W-1:0] dest_EXE,
    input  logic             WB_EN_EXE,
    input  logic             MEM_R_EN_EXE,
    input  logic [REG_W-1:0] dest_MEM,
    input  logic             WB_EN_MEM,
    input  logic             B_EXE,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             freeze_front,
    output logic             freeze_back,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    logic              hazard;
    logic              mstall;
    act_t              act;
    ctrl_t             ctrl;
    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    hazard_cmp u_hazard_cmp (
        .fwd_en       (fwd_en),
        .src1_ID      (src1_ID),
        .src2_ID      (src2_ID),
        .src1_vld_ID  (src1_vld_ID),
        .src2_vld_ID  (src2_vld_ID),
        .dest_EXE     (dest_EXE),
        .WB_EN_EXE    (WB_EN_EXE),
        .MEM_R_EN_EXE (MEM_R_EN_EXE),
        .dest_MEM     (dest_MEM),
        .WB_EN_MEM    (WB_EN_MEM),
        .hazard       (hazard)
    );

    assign mstall = mem_req_MEM & ~mem_ready;

    // A stall never flushes, so a held branch fires once memory releases.
    always_comb begin
        act = ACT_NONE;
        unique case (1'b1)
            rst & mstall:                     act = ACT_STALL;
            rst & ~mstall & B_EXE:            act = ACT_FLUSH;
            rst & ~mstall & ~B_EXE & hazard:  act = ACT_BUBBLE;
            default:                          act = ACT_NONE;
        endcase
    end

    assign ctrl         = act_ctrl(act);
    assign freeze_front = ctrl.freeze_front;
    assign freeze_back  = ctrl.freeze_back;
    assign flush_IF     = ctrl.flush_IF;
    assign flush_ID     = ctrl.flush_ID;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (mstall) begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready | ~mem_req_MEM) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        wait_nxt = '0;
        if (state == MEM_WAIT) begin
            if (wait_cnt == WAIT_MAX) begin
                wait_nxt = wait_cnt;
            end else begin
                wait_nxt = wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Watchdog is report-only; it does not touch the freeze outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (cnt_clr) begin
                mem_timeout <= 1'b0;
            end else if (wait_nxt == WAIT_MAX) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (act == ACT_STALL && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (act == ACT_BUBBLE && !(&bubble_cnt)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (act == ACT_FLUSH && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, corner sequences and
// randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO   = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          fwd_en;
    logic [3:0]    src1_ID;
    logic [3:0]    src2_ID;
    logic          src1_vld_ID;
    logic          src2_vld_ID;
    logic [3:0]    dest_EXE;
    logic          WB_EN_EXE;
    logic          MEM_R_EN_EXE;
    logic [3:0]    dest_MEM;
    logic          WB_EN_MEM;
    logic          B_EXE;
    logic          mem_req_MEM;
    logic          mem_ready;
    logic          cnt_clr;
    logic          freeze_front;
    logic          freeze_back;
    logic          flush_IF;
    logic          flush_ID;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;
    logic [CW-1:0] flush_cnt;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .src1_ID      (src1_ID),
        .src2_ID      (src2_ID),
        .src1_vld_ID  (src1_vld_ID),
        .src2_vld_ID  (src2_vld_ID),
        .dest_EXE     (dest_EXE),
        .WB_EN_EXE    (WB_EN_EXE),
        .MEM_R_EN_EXE (MEM_R_EN_EXE),
        .dest_MEM     (dest_MEM),
        .WB_EN_MEM    (WB_EN_MEM),
        .B_EXE        (B_EXE),
        .mem_req_MEM  (mem_req_MEM),
        .mem_ready    (mem_ready),
        .cnt_clr      (cnt_clr),
        .freeze_front (freeze_front),
        .freeze_back  (freeze_back),
        .flush_IF     (flush_IF),
        .flush_ID     (flush_ID),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fwd;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       v1;
        logic       v2;
        logic [3:0] de;
        logic       wbe;
        logic       mre;
        logic [3:0] dm;
        logic       wbm;
        logic       b;
        logic       req;
        logic       rdy;
        logic [3:0] exp;
    } vec_t;

    vec_t vt[12];

    int checks = 0;
    int errors = 0;

    int m_stall  = 0;
    int m_bubble = 0;
    int m_flush  = 0;
    int m_run    = 0;
    bit m_wait   = 0;
    bit m_tmo    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit prod(input logic [3:0] r);
        if (fwd_en)
            return MEM_R_EN_EXE && dest_EXE == r;
        return (WB_EN_EXE && dest_EXE == r) || (WB_EN_MEM && dest_MEM == r);
    endfunction

    // {freeze_front, freeze_back, flush_IF, flush_ID}
    function automatic int exp_ctl();
        bit hz;
        bit ms;
        if (!rst) return 0;
        ms = mem_req_MEM && !mem_ready;
        hz = (src1_vld_ID && prod(src1_ID)) || (src2_vld_ID && prod(src2_ID));
        if (ms) return 4'b1100;
        if (B_EXE) return 4'b0011;
        if (hz) return 4'b1001;
        return 0;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check_outs();
        int e;
        e = exp_ctl();
        chk("freeze_front", freeze_front, e[3]);
        chk("freeze_back", freeze_back, e[2]);
        chk("flush_IF", flush_IF, e[1]);
        chk("flush_ID", flush_ID, e[0]);
        chk("mem_timeout", mem_timeout, m_tmo);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("bubble_cnt", bubble_cnt, m_bubble);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic model_edge();
        int e;
        e = exp_ctl();
        if (!rst) begin
            m_stall = 0; m_bubble = 0; m_flush = 0;
            m_run = 0; m_wait = 0; m_tmo = 0;
            return;
        end
        m_run = m_wait ? ((m_run < TO) ? m_run + 1 : TO) : 0;
        m_wait = mem_req_MEM && !mem_ready;
        if (cnt_clr) begin
            m_stall = 0; m_bubble = 0; m_flush = 0; m_tmo = 0;
        end else begin
            if (m_run == TO) m_tmo = 1;
            if (e == 4'b1100) m_stall = sat(m_stall + 1);
            if (e == 4'b1001) m_bubble = sat(m_bubble + 1);
            if (e == 4'b0011) m_flush = sat(m_flush + 1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        fwd_en = 0; src1_ID = 0; src2_ID = 0;
        src1_vld_ID = 0; src2_vld_ID = 0;
        dest_EXE = 0; WB_EN_EXE = 0; MEM_R_EN_EXE = 0;
        dest_MEM = 0; WB_EN_MEM = 0; B_EXE = 0;
        mem_req_MEM = 0; mem_ready = 0; cnt_clr = 0;
    endtask

    task automatic clear();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    initial begin
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000};
        vt[1]  = '{1, 1, 3, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 4'b1001};
        vt[2]  = '{0, 5, 2, 1, 1, 9, 0, 0, 5, 1, 0, 0, 0, 4'b1001};
        vt[3]  = '{1, 5, 2, 1, 1, 9, 0, 0, 5, 1, 0, 0, 0, 4'b0000};
        vt[4]  = '{1, 3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 4'b0000};
        vt[5]  = '{0, 1, 7, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 4'b1001};
        vt[6]  = '{1, 0, 3, 0, 1, 3, 1, 1, 0, 0, 1, 0, 0, 4'b0011};
        vt[7]  = '{0, 4, 4, 1, 1, 4, 1, 0, 4, 1, 0, 1, 1, 4'b1001};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1100};
        vt[9]  = '{1, 0, 6, 1, 0, 0, 0, 1, 6, 1, 0, 0, 0, 4'b1001};
        vt[10] = '{1, 2, 2, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 4'b0000};
        vt[11] = '{0, 8, 8, 1, 1, 3, 1, 0, 9, 1, 0, 0, 0, 4'b0000};

        idle();
        rst = 0;
        mem_req_MEM = 1;
        B_EXE = 1;
        @(posedge clk);
        model_edge();
        #1;
        tick();
        chk("rst_freeze_front", freeze_front, 0);
        chk("rst_flush_IF", flush_IF, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mem_timeout", mem_timeout, 0);
        rst = 1;
        idle();
        tick();

        foreach (vt[i]) begin
            fwd_en = vt[i].fwd; src1_ID = vt[i].s1; src2_ID = vt[i].s2;
            src1_vld_ID = vt[i].v1; src2_vld_ID = vt[i].v2;
            dest_EXE = vt[i].de; WB_EN_EXE = vt[i].wbe;
            MEM_R_EN_EXE = vt[i].mre; dest_MEM = vt[i].dm;
            WB_EN_MEM = vt[i].wbm; B_EXE = vt[i].b;
            mem_req_MEM = vt[i].req; mem_ready = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d_ctl", i),
                {freeze_front, freeze_back, flush_IF, flush_ID}, vt[i].exp);
            tick();
        end
        idle();
        tick();

        // Load-use bubble increments bubble_cnt by one.
        clear();
        fwd_en = 1; MEM_R_EN_EXE = 1; WB_EN_EXE = 1; dest_EXE = 3;
        src2_ID = 3; src2_vld_ID = 1;
        tick();
        idle();
        chk("lu_bubble_cnt", bubble_cnt, 1);

        // Four-cycle memory stall.
        clear();
        mem_req_MEM = 1;
        repeat (4) begin
            tick();
            chk("ms_freeze_back", freeze_back, 1);
        end
        mem_ready = 1;
        #1;
        chk("ms_release", freeze_front, 0);
        tick();
        idle();
        chk("ms_stall_cnt", stall_cnt, 4);
        tick();

        // Branch held under a three-cycle stall flushes once afterwards.
        clear();
        B_EXE = 1; mem_req_MEM = 1;
        repeat (3) begin
            tick();
            chk("br_no_flush", flush_IF | flush_ID, 0);
        end
        mem_ready = 1;
        #1;
        chk("br_flush_IF", flush_IF, 1);
        chk("br_flush_ID", flush_ID, 1);
        tick();
        idle();
        tick();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 3);

        // Watchdog: sets after TO cycles in MEM_WAIT, sticky until cnt_clr.
        clear();
        mem_req_MEM = 1;
        repeat (TO) tick();
        chk("wd_before", mem_timeout, 0);
        tick();
        chk("wd_set", mem_timeout, 1);
        chk("wd_no_freeze_change", freeze_front, 1);
        repeat (3) tick();
        idle();
        tick();
        chk("wd_sticky", mem_timeout, 1);
        clear();
        chk("wd_clr", mem_timeout, 0);
        chk("wd_clr_stall_cnt", stall_cnt, 0);

        // Reset in the middle of a wait.
        mem_req_MEM = 1;
        repeat (3) tick();
        rst = 0;
        #1;
        chk("rst_mid_freeze", freeze_front | freeze_back, 0);
        tick();
        chk("rst_mid_stall_cnt", stall_cnt, 0);
        rst = 1;
        idle();
        tick();

        for (int n = 0; n < 2000; n++) begin
            fwd_en = $urandom_range(0, 1);
            src1_ID = 4'($urandom_range(0, 3));
            src2_ID = 4'($urandom_range(0, 3));
            src1_vld_ID = $urandom_range(0, 3) != 0;
            src2_vld_ID = $urandom_range(0, 1);
            dest_EXE = 4'($urandom_range(0, 3));
            dest_MEM = 4'($urandom_range(0, 3));
            WB_EN_EXE = $urandom_range(0, 1);
            MEM_R_EN_EXE = $urandom_range(0, 1);
            WB_EN_MEM = $urandom_range(0, 1);
            B_EXE = $urandom_range(0, 7) == 0;
            if ((n % 128) < 24) begin
                mem_req_MEM = 1;
                mem_ready = $urandom_range(0, 15) == 0;
            end else begin
                mem_req_MEM = $urandom_range(0, 1);
                mem_ready = $urandom_range(0, 2) == 0;
            end
            cnt_clr = $urandom_range(0, 299) == 0;
            rst = $urandom_range(0, 149) != 0;
            tick();
        end
        rst = 1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control block that drives the freeze and flush inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It resolves three events: load-use and RAW hazards seen in ID, taken branches resolved in EXE, and cache/SRAM stalls in MEM. A small FSM tracks memory-wait episodes and runs a watchdog on them. Saturating performance counters record stall, bubble and flush activity. It is instantiated once in the top-level pipeline, between the stage registers and the cache controller.

## Interface
Parameters:
- TIMEOUT, 1024: maximum consecutive MEM_WAIT cycles before mem_timeout is set.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- fwd_en  in  1  forwarding unit enabled.
- src1_ID, src2_ID  in  4 each  source register numbers of the instruction in ID.
- src1_vld_ID, src2_vld_ID  in  1 each  the source is actually read.
- dest_EXE  in  4  destination register of the instruction in EXE.
- WB_EN_EXE, MEM_R_EN_EXE  in  1 each  write-back and load flags of the instruction in EXE.
- dest_MEM  in  4  destination register of the instruction in MEM.
- WB_EN_MEM  in  1  write-back flag of the instruction in MEM.
- B_EXE  in  1  taken branch resolved in EXE.
- mem_req_MEM  in  1  MEM stage holds a load or store (MEM_R_EN_MEM | MEM_W_EN_MEM).
- mem_ready  in  1  cache/SRAM controller completes the MEM access this cycle.
- cnt_clr  in  1  synchronous clear of the counters and of mem_timeout.
- freeze_front  out  1  hold PC and IF/ID.
- freeze_back  out  1  hold ID/EXE, EXE/MEM and MEM/WB.
- flush_IF  out  1  clear IF/ID.
- flush_ID  out  1  clear ID/EXE (flush has priority over freeze in that register).
- mem_timeout  out  1  sticky watchdog error.
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  event counters.

## Operation
- Hazard compare: hz1 = src1_vld_ID & src1_ID matches a producer; hz2 is the same for src2.
  - fwd_en=1: the only producer is EXE with MEM_R_EN_EXE=1 (load-use).
  - fwd_en=0: producers are EXE with WB_EN_EXE=1 and MEM with WB_EN_MEM=1.
  - hazard = hz1 | hz2.
- Memory stall: mstall = mem_req_MEM & ~mem_ready.
- Priority is mstall > B_EXE > hazard:
  - mstall: freeze_front=1, freeze_back=1, flush_IF=0, flush_ID=0. Never flush during a stall, so a held branch or instruction survives.
  - B_EXE (no mstall): flush_IF=1, flush_ID=1, freeze_front=0, freeze_back=0. A hazard in ID is ignored because that instruction is squashed.
  - hazard only: freeze_front=1, flush_ID=1 (bubble), flush_IF=0, freeze_back=0.
  - none: all four outputs 0.
- FSM states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when mstall=1.
  - MEM_WAIT -> RUN when mem_ready=1 or mem_req_MEM=0.
  - MEM_WAIT is otherwise held.
- Watchdog: wait_cnt clears in RUN and increments in MEM_WAIT, saturating at TIMEOUT.
  - When wait_cnt reaches TIMEOUT, mem_timeout is set and stays set until cnt_clr or reset.
  - The watchdog never alters the freeze outputs.
- Counters, all saturating at all-ones:
  - stall_cnt increments each cycle mstall=1.
  - bubble_cnt increments each cycle the hazard-only case applies.
  - flush_cnt increments each cycle the B_EXE case applies.
  - cnt_clr has priority over increments: the cycle after cnt_clr, the counters read 0.

## Timing
- freeze_*/flush_* are combinational from the inputs, with zero-cycle latency. The state register does not gate them.
- rst=0 at a clock edge sets: state RUN, wait_cnt 0, mem_timeout 0, all counters 0.
- While rst=0, the four freeze/flush outputs are forced to 0.
- Reset asserted mid-MEM_WAIT returns the block to RUN at that edge. No pending state survives.
- mem_ready=1 in the same cycle mem_req_MEM rises is not a stall: no freeze, and the FSM stays in RUN.
- B_EXE with mstall: the stall is applied. The branch flush occurs in the first cycle mstall=0, because B_EXE is still held in ID/EXE.
- The counters and mem_timeout change one cycle after the causing event.

## Structure
- pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT};
  - REG_W=4;
  - the encoded action type {ACT_NONE, ACT_BUBBLE, ACT_FLUSH, ACT_STALL}, shared with trace monitors.
- One sub-module, hazard_cmp: a combinational source/destination compare producing hazard from the ID and producer fields.
- pipe_hazard_ctrl contains the priority logic, the FSM, the watchdog and the counters.

## Test plan
- LDR r3 in EXE (MEM_R_EN_EXE=1, dest_EXE=3), fwd_en=1, src2_ID=3 valid -> one cycle with freeze_front=1, flush_ID=1; bubble_cnt 0->1.
- fwd_en=0, WB_EN_MEM=1, dest_MEM=5, src1_ID=5 valid -> bubble. Repeat with fwd_en=1 -> no bubble.
- mem_req_MEM=1, mem_ready=0 for 4 cycles then 1 -> freeze_front=freeze_back=1 for 4 cycles, FSM returns to RUN, stall_cnt=4.
- B_EXE=1 during a 3-cycle memory stall -> no flush for 3 cycles, then flush_IF=flush_ID=1 for 1 cycle; flush_cnt=1.
- TIMEOUT=8, mem_ready held 0 -> mem_timeout rises once wait_cnt reaches 8 and stays set. cnt_clr pulse -> mem_timeout=0 and all counters 0. rst=0 mid-wait -> RUN, all outputs 0.
